ga_run_ctrl: RTL
================

Name: ga_run_ctrl

Overview:
Run controller placed between the board-level start input, the HLS GA core (ga_top, ap_start/ap_done style) and the UART transmitter. It performs these steps in order:
- detects a start request and holds the core's start line until the core reports completion;
- latches the best X/Y/Z result;
- streams the result as a fixed byte frame through the uart_tx byte handshake.

It also provides a run timeout and sticky status flags for LEDs/debug.

Parameters:
TIMEOUT_CYCLES, 32'd10_000_000, max CLK_i cycles in RUN before abort (0 disables timeout)
SYNC_BYTE, 8'hA5, header byte sent first in every frame

Ports:
CLK_i  in  1  system clock
RSTN_i  in  1  reset, asynchronous, active-low
EN_i  in  1  start request; rising edge starts a run
GA_START_o  out  1  to core ap_start/start
GA_DONE_i  in  1  core finished flag (ap_done / result_finished_flag)
GA_X_i  in  28  core best x
GA_Y_i  in  28  core best y
GA_Z_i  in  28  core best fitness
X_o  out  28  latched best x
Y_o  out  28  latched best y
Z_o  out  28  latched best fitness
TX_DV_o  out  1  one-cycle byte-valid strobe to uart_tx
TX_BYTE_o  out  8  byte to uart_tx
TX_DONE_i  in  1  uart_tx byte-complete pulse
BUSY_o  out  1  high in any state other than IDLE
FINISHED_o  out  1  sticky: last run completed and frame sent
TIMEOUT_o  out  1  sticky: last run aborted by timeout

Behaviour:
- Reset (RSTN_i low, async): state=IDLE. All outputs 0, byte index 0, timeout counter 0, EN_i edge register 0.
- Edge detect: EN_i is registered each cycle. A rise is EN_i=1 while the registered value is 0. A rise outside IDLE is ignored. EN_i held high does not retrigger.
- IDLE -> RUN on a rise seen at edge N. At edge N:
  - FINISHED_o and TIMEOUT_o clear;
  - the counter clears;
  - GA_START_o=1 from the cycle after edge N.
- RUN:
  - GA_START_o held 1; the counter increments each cycle.
  - If GA_DONE_i=1 at edge M: X_o/Y_o/Z_o load GA_*_i at M, GA_START_o=0 after M, and the state goes to SEND.
  - Else, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: TIMEOUT_o=1, GA_START_o=0, state -> IDLE, X/Y/Z_o unchanged, no frame sent.
  - If GA_DONE_i and timeout occur in the same cycle, done wins.
- Frame content: byte 0 = SYNC_BYTE. Bytes 1-4 = {4'b0,X_o}, bytes 5-8 = {4'b0,Y_o}, bytes 9-12 = {4'b0,Z_o}, each word MSB byte first. Frame length is 13 bytes (14 with the optional feature).
- SEND: TX_DV_o=1 for exactly one cycle with TX_BYTE_o = frame[idx], then WAIT_TX. The first TX_DV_o occurs the cycle after M+1, i.e. 2 cycles after done is sampled.
- WAIT_TX:
  - TX_BYTE_o held stable.
  - On TX_DONE_i=1: if idx is the last byte, go to DONE; else idx+1 and go to SEND.
  - TX_DONE_i in any other state is ignored.
- DONE: FINISHED_o=1 and idx=0 for one cycle, then IDLE. FINISHED_o stays high until the next accepted start or reset.
- GA_DONE_i outside RUN is ignored. The latched outputs never change except on the capture edge.
- Reset mid-run or mid-frame aborts immediately. GA_START_o and TX_DV_o go low asynchronously; a partially sent frame is not resumed.

Optional Feature:
GA_FRAME_CHECKSUM_EN:
- Defined: a 14th byte is appended, equal to the XOR of bytes 1..12. Bytes are folded into a running XOR register as they are sent, and the register clears at frame start.
- Undefined: the frame is 13 bytes, with no checksum logic or register.

Test Plan:
1. Reset released, EN_i low for 50 cycles -> all outputs 0, BUSY_o=0, TX_DV_o never asserted.
2. EN_i rise; GA_DONE_i pulse after 20 cycles with X=0x0010000, Y=0x0038000, Z=0x007C000; TX_DONE_i 5 cycles after each TX_DV_o:
   - frame A5 00 01 00 00 00 03 80 00 00 07 C0 00, plus 45 with GA_FRAME_CHECKSUM_EN;
   - FINISHED_o=1 after the last TX_DONE_i;
   - GA_START_o high for exactly 21 cycles.
3. TIMEOUT_CYCLES=100, GA_DONE_i never asserted -> TIMEOUT_o=1 and GA_START_o=0 100 cycles after the start, no TX_DV_o, BUSY_o=0.
4. Second EN_i rise during WAIT_TX of byte 3 -> ignored; frame completes unchanged. Then a new rise clears FINISHED_o and starts a new run.
5. RSTN_i low for 1 cycle during WAIT_TX of byte 7 -> outputs 0 immediately, state IDLE. A new run sends a full frame starting at A5.
6. GA_DONE_i asserted in the same cycle the timeout count is reached -> capture occurs, TIMEOUT_o stays 0, frame sent.

Source files
------------

// File: rtl/ga_run_ctrl.sv
// ga_run_ctrl: holds the GA core start line until done, latches the best X/Y/Z result,
// then streams it as a byte frame to uart_tx. Define GA_FRAME_CHECKSUM_EN to append an XOR checksum byte.
module ga_run_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        CLK_i,
    input  logic        RSTN_i,
    input  logic        EN_i,
    output logic        GA_START_o,
    input  logic        GA_DONE_i,
    input  logic [27:0] GA_X_i,
    input  logic [27:0] GA_Y_i,
    input  logic [27:0] GA_Z_i,
    output logic [27:0] X_o,
    output logic [27:0] Y_o,
    output logic [27:0] Z_o,
    output logic        TX_DV_o,
    output logic [7:0]  TX_BYTE_o,
    input  logic        TX_DONE_i,
    output logic        BUSY_o,
    output logic        FINISHED_o,
    output logic        TIMEOUT_o
);

`ifdef GA_FRAME_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd13;
`else
    localparam logic [3:0] LAST_IDX = 4'd12;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_TX = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic        en_r;
    logic        rise_s;
    logic [31:0] cnt_r, cnt_s;
    logic [3:0]  idx_r, idx_s;
    logic [27:0] x_r, x_s, y_r, y_s, z_r, z_s;
    logic        ga_start_r, ga_start_s;
    logic        tx_dv_r, tx_dv_s;
    logic [7:0]  tx_byte_r, tx_byte_s;
    logic [7:0]  byte_s;
    logic        busy_r, busy_s;
    logic        finished_r, finished_s;
    logic        timeout_r, timeout_s;
`ifdef GA_FRAME_CHECKSUM_EN
    logic [7:0]  csum_r, csum_s;
`endif

    // Payload words are zero-extended to 32 bits and sent MSB byte first.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                              input logic [27:0] x,
                                              input logic [27:0] y,
                                              input logic [27:0] z);
        logic [31:0] wx, wy, wz;
        wx = {4'b0000, x};
        wy = {4'b0000, y};
        wz = {4'b0000, z};
        case (idx)
            4'd0:    frame_byte = SYNC_BYTE;
            4'd1:    frame_byte = wx[31:24];
            4'd2:    frame_byte = wx[23:16];
            4'd3:    frame_byte = wx[15:8];
            4'd4:    frame_byte = wx[7:0];
            4'd5:    frame_byte = wy[31:24];
            4'd6:    frame_byte = wy[23:16];
            4'd7:    frame_byte = wy[15:8];
            4'd8:    frame_byte = wy[7:0];
            4'd9:    frame_byte = wz[31:24];
            4'd10:   frame_byte = wz[23:16];
            4'd11:   frame_byte = wz[15:8];
            4'd12:   frame_byte = wz[7:0];
            default: frame_byte = 8'h00;
        endcase
    endfunction

    assign rise_s = EN_i & ~en_r;

    // Next-state and next-output computation for every registered signal.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        x_s        = x_r;
        y_s        = y_r;
        z_s        = z_r;
        ga_start_s = ga_start_r;
        tx_dv_s    = 1'b0;
        tx_byte_s  = tx_byte_r;
        finished_s = finished_r;
        timeout_s  = timeout_r;
        byte_s     = 8'h00;
`ifdef GA_FRAME_CHECKSUM_EN
        csum_s     = csum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_s    = ST_RUN;
                    finished_s = 1'b0;
                    timeout_s  = 1'b0;
                    cnt_s      = 32'd0;
                    ga_start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Done has priority over a timeout landing on the same edge.
                if (GA_DONE_i) begin
                    x_s        = GA_X_i;
                    y_s        = GA_Y_i;
                    z_s        = GA_Z_i;
                    ga_start_s = 1'b0;
                    idx_s      = 4'd0;
                    state_s    = ST_SEND;
`ifdef GA_FRAME_CHECKSUM_EN
                    csum_s     = 8'h00;
`endif
                end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_r == (TIMEOUT_CYCLES - 32'd1))) begin
                    timeout_s  = 1'b1;
                    ga_start_s = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            ST_SEND: begin
                byte_s = frame_byte(idx_r, x_r, y_r, z_r);
`ifdef GA_FRAME_CHECKSUM_EN
                if (idx_r == LAST_IDX) begin
                    byte_s = csum_r;
                end else if (idx_r != 4'd0) begin
                    csum_s = csum_r ^ byte_s;
                end else begin
                    csum_s = csum_r;
                end
`endif
                tx_dv_s   = 1'b1;
                tx_byte_s = byte_s;
                state_s   = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (TX_DONE_i) begin
                    if (idx_r == LAST_IDX) begin
                        finished_s = 1'b1;
                        state_s    = ST_DONE;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_WAIT_TX;
                end
            end
            ST_DONE: begin
                idx_s   = 4'd0;
                state_s = ST_IDLE;
            end
            default: begin
                ga_start_s = 1'b0;
                idx_s      = 4'd0;
                state_s    = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            state_r    <= ST_IDLE;
            en_r       <= 1'b0;
            cnt_r      <= 32'd0;
            idx_r      <= 4'd0;
            x_r        <= 28'd0;
            y_r        <= 28'd0;
            z_r        <= 28'd0;
            ga_start_r <= 1'b0;
            tx_dv_r    <= 1'b0;
            tx_byte_r  <= 8'h00;
            busy_r     <= 1'b0;
            finished_r <= 1'b0;
            timeout_r  <= 1'b0;
`ifdef GA_FRAME_CHECKSUM_EN
            csum_r     <= 8'h00;
`endif
        end else begin
            state_r    <= state_s;
            en_r       <= EN_i;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            x_r        <= x_s;
            y_r        <= y_s;
            z_r        <= z_s;
            ga_start_r <= ga_start_s;
            tx_dv_r    <= tx_dv_s;
            tx_byte_r  <= tx_byte_s;
            busy_r     <= busy_s;
            finished_r <= finished_s;
            timeout_r  <= timeout_s;
`ifdef GA_FRAME_CHECKSUM_EN
            csum_r     <= csum_s;
`endif
        end
    end

    assign GA_START_o = ga_start_r;
    assign X_o        = x_r;
    assign Y_o        = y_r;
    assign Z_o        = z_r;
    assign TX_DV_o    = tx_dv_r;
    assign TX_BYTE_o  = tx_byte_r;
    assign BUSY_o     = busy_r;
    assign FINISHED_o = finished_r;
    assign TIMEOUT_o  = timeout_r;

endmodule
